// File: rtl/counter_burst_arbiter.sv
// Round-robin arbiter sharing one dual-channel event counter among NREQ burst requesters.
// Optional feature: define ABORT_EN to add the Abort input (early burst termination).
module counter_burst_arbiter #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 8,
  parameter int IDX_W = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
`ifdef ABORT_EN
  input  logic                  Abort,
`endif
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ-1:0]       ReqSlt,
  input  logic [NREQ*LEN_W-1:0] ReqLen,
  output logic [NREQ-1:0]       Gnt,
  output logic [NREQ-1:0]       Done,
  output logic                  CntEn,
  output logic                  CntSlt,
  output logic                  Busy,
  output logic [IDX_W-1:0]      Owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] rem, rem_nx;
  logic [IDX_W-1:0] last, last_nx, owner_nx;
  logic [NREQ-1:0]  gnt_nx, done_nx;
  logic             cnten_nx, cntslt_nx;
  logic             found;
  logic [IDX_W-1:0] pick, cand;
  logic             pick_slt;
  logic [LEN_W-1:0] pick_len;
  logic             abort_run;

`ifdef ABORT_EN
  assign abort_run = Abort;
`else
  assign abort_run = 1'b0;
`endif

  // Search last+1, last+2, ... so the previous winner has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((k + 32'(last)) % NREQ);
      if (!found && Req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_slt = 1'b0;
    pick_len = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_slt = ReqSlt[i];
        pick_len = ReqLen[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rem_nx    = rem;
    last_nx   = last;
    owner_nx  = Owner;
    gnt_nx    = '0;
    done_nx   = '0;
    cnten_nx  = 1'b0;
    cntslt_nx = CntSlt;
    case (state)
      IDLE: begin
        if (found) begin
          last_nx   = pick;
          owner_nx  = pick;
          gnt_nx    = NREQ'(1) << pick;
          cntslt_nx = pick_slt;
          rem_nx    = pick_len;
          if (pick_len != '0) begin
            state_nx = RUN;
            cnten_nx = 1'b1;
          end else begin
            state_nx = DONE;
          end
        end
      end
      RUN: begin
        rem_nx = rem - LEN_W'(1);
        if (abort_run || rem == LEN_W'(1)) begin
          state_nx = DONE;
          done_nx  = NREQ'(1) << Owner;
        end else begin
          cnten_nx = 1'b1;
        end
      end
      DONE: begin
        // A zero-length burst enters DONE straight from the grant with Done still low,
        // so it spends one extra cycle here to emit its Done pulse after the Gnt.
        if (Done == '0) begin
          done_nx = NREQ'(1) << Owner;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      rem    <= '0;
      last   <= IDX_W'(NREQ - 1);
      Owner  <= '0;
      Gnt    <= '0;
      Done   <= '0;
      CntEn  <= 1'b0;
      CntSlt <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      rem    <= rem_nx;
      last   <= last_nx;
      Owner  <= owner_nx;
      Gnt    <= gnt_nx;
      Done   <= done_nx;
      CntEn  <= cnten_nx;
      CntSlt <= cntslt_nx;
      Busy   <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_counter_burst_arbiter.sv
// Self-checking bench for counter_burst_arbiter: window-based burst model plus directed and random stimulus.
// Define ABORT_EN to also exercise the Abort input.
module tb_counter_burst_arbiter;
  localparam int NREQ  = 4;
  localparam int LEN_W = 8;
  localparam int IDX_W = 2;

  logic                  Clk = 1'b0;
  logic                  Reset_n;
  logic [NREQ-1:0]       Req;
  logic [NREQ-1:0]       ReqSlt;
  logic [NREQ*LEN_W-1:0] ReqLen;
  logic [NREQ-1:0]       Gnt;
  logic [NREQ-1:0]       Done;
  logic                  CntEn;
  logic                  CntSlt;
  logic                  Busy;
  logic [IDX_W-1:0]      Owner;
`ifdef ABORT_EN
  logic                  Abort;
`endif

  counter_burst_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .IDX_W(IDX_W)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
`ifdef ABORT_EN
    .Abort  (Abort),
`endif
    .Req    (Req),
    .ReqSlt (ReqSlt),
    .ReqLen (ReqLen),
    .Gnt    (Gnt),
    .Done   (Done),
    .CntEn  (CntEn),
    .CntSlt (CntSlt),
    .Busy   (Busy),
    .Owner  (Owner)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++)
      if (v[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  // Model: each burst is a set of cycle windows (grant, enable span, done, busy span).
  int m_ge = -100, m_cl = -101, m_d = -100, m_free = 0;
  int m_idx = 0, m_slt = 0, m_len = 0, m_last = NREQ - 1, m_owner = 0;
  int pj;
  bit pf;

  always @(posedge Clk) begin
    cyc++;
    if (!Reset_n) begin
      m_ge = -100; m_cl = -101; m_d = -100; m_free = 0;
      m_last = NREQ - 1; m_owner = 0;
    end else begin
`ifdef ABORT_EN
      if (Abort && (cyc - 1) >= m_ge && (cyc - 1) <= m_cl) begin
        m_cl = cyc - 1; m_d = cyc; m_free = cyc + 2;
      end
`endif
      if (cyc >= m_free && Req != '0) begin
        pf = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          pj = (m_last + k) % NREQ;
          if (!pf && Req[pj]) begin pf = 1'b1; m_idx = pj; end
        end
        m_len   = int'(ReqLen[m_idx*LEN_W +: LEN_W]);
        m_slt   = int'(ReqSlt[m_idx]);
        m_ge    = cyc;
        m_cl    = cyc + m_len - 1;
        m_d     = cyc + ((m_len == 0) ? 1 : m_len);
        m_free  = m_d + 2;
        m_last  = m_idx;
        m_owner = m_idx;
      end
    end
    #1;
    chk("gnt",   int'(Gnt),   (cyc == m_ge) ? (1 << m_idx) : 0);
    chk("done",  int'(Done),  (cyc == m_d)  ? (1 << m_idx) : 0);
    chk("cnten", int'(CntEn), (cyc >= m_ge && cyc <= m_cl) ? 1 : 0);
    chk("busy",  int'(Busy),  (cyc >= m_ge && cyc <= m_d)  ? 1 : 0);
    chk("owner", int'(Owner), m_owner);
    if (cyc >= m_ge && cyc <= m_cl) chk("cntslt", int'(CntSlt), m_slt);
  end

  task automatic burst(input int i, input int slt, input int len, output int t0,
                       output int gc, output int dc, output int en0, output int en1, output int bz);
    @(negedge Clk);
    Req = '0;
    Req[i] = 1'b1;
    ReqSlt[i] = slt[0];
    ReqLen[i*LEN_W +: LEN_W] = len[LEN_W-1:0];
    t0 = cyc;
    gc = -1; dc = -1; en0 = 0; en1 = 0; bz = 0;
    for (int n = 0; n < 300 && dc < 0; n++) begin
      @(posedge Clk); #1;
      if (Gnt[i]) gc = cyc;
      if (CntEn) begin
        if (CntSlt) en1++;
        else en0++;
      end
      if (Busy) bz++;
      if (Done[i]) dc = cyc;
      if (gc >= 0 && Req[i]) begin
        @(negedge Clk);
        Req[i] = 1'b0;
      end
    end
    repeat (2) @(negedge Clk);
  endtask

  int t0, gc, dc, en0, en1, bz, k, ndone, first_gnt;
  int order[5];
  int gcs[5];

  initial begin
    Reset_n = 1'b0;
    Req = '0;
    ReqSlt = '0;
    ReqLen = '0;
`ifdef ABORT_EN
    Abort = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    chk("reset_outputs", int'({Gnt, Done, CntEn, CntSlt, Busy, Owner}), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Single burst on channel 0
    burst(1, 0, 3, t0, gc, dc, en0, en1, bz);
    chk("single_gnt_cycle", gc, t0 + 1);
    chk("single_done_cycle", dc, t0 + 4);
    chk("single_out0_incr", en0, 3);
    chk("single_out1_en", en1, 0);
    chk("single_owner", int'(Owner), 1);

    // Channel 1 burst: 8 enables -> Output1 advances by 2
    burst(2, 1, 8, t0, gc, dc, en0, en1, bz);
    chk("ch1_en_cycles", en1, 8);
    chk("ch1_out1_incr", en1 / 4, 2);
    chk("ch1_out0_en", en0, 0);
    chk("ch1_done_latency", dc - gc, 8);

    // Zero-length burst
    burst(3, 0, 0, t0, gc, dc, en0, en1, bz);
    chk("zero_gnt_cycle", gc, t0 + 1);
    chk("zero_no_cnten", en0 + en1, 0);
    chk("zero_done_next", dc, gc + 1);
    chk("zero_busy_cycles", bz, 2);

    // Round-robin with all requesters held, len=1
    @(negedge Clk);
    Req = '1;
    ReqSlt = 4'b0101;
    ReqLen = {NREQ{8'd1}};
    k = 0;
    for (int n = 0; n < 100 && k < 5; n++) begin
      @(posedge Clk); #1;
      if (Gnt != '0) begin
        order[k] = oh_idx(Gnt);
        gcs[k] = cyc;
        k++;
        if (k == 5) begin
          @(negedge Clk);
          Req = '0;
        end
      end
    end
    chk("rr_grant_count", k, 5);
    for (int j = 0; j < 5; j++) chk("rr_order", order[j], j % NREQ);
    for (int j = 1; j < 5; j++) chk("rr_spacing", gcs[j] - gcs[j-1], 3);
    repeat (4) @(negedge Clk);

    // Reset in the middle of a burst (rem=5), then requester 0 wins first
    @(negedge Clk);
    Req = 4'b0010;
    ReqLen[1*LEN_W +: LEN_W] = 8'd8;
    gc = -1;
    for (int n = 0; n < 20 && gc < 0; n++) begin
      @(posedge Clk); #1;
      if (Gnt[1]) gc = cyc;
    end
    chk("rst_burst_granted", gc >= 0 ? 1 : 0, 1);
    @(negedge Clk);
    Req = '0;
    repeat (3) @(negedge Clk);
    chk("rst_burst_active", int'(CntEn), 1);
    Reset_n = 1'b0;
    #1;
    chk("rst_midburst_outputs", int'({Gnt, Done, CntEn, CntSlt, Busy, Owner}), 0);
    Req = '1;
    ReqLen = {NREQ{8'd2}};
    @(negedge Clk);
    Reset_n = 1'b1;
    ndone = 0;
    first_gnt = 0;
    for (int n = 0; n < 20 && first_gnt == 0; n++) begin
      @(posedge Clk); #1;
      if (Done != '0) ndone++;
      if (Gnt != '0) first_gnt = int'(Gnt);
    end
    chk("rst_first_gnt", first_gnt, 1);
    chk("rst_no_done", ndone, 0);
    @(negedge Clk);
    Req = '0;
    repeat (6) @(negedge Clk);

`ifdef ABORT_EN
    // Abort during the 4th enabled cycle of a 10-cycle burst
    Req = 4'b0001;
    ReqLen[0 +: LEN_W] = 8'd10;
    gc = -1;
    for (int n = 0; n < 20 && gc < 0; n++) begin
      @(posedge Clk); #1;
      if (Gnt[0]) gc = cyc;
    end
    en0 = (gc >= 0 && CntEn) ? 1 : 0;
    dc = -1;
    for (int n = 1; n < 30 && dc < 0; n++) begin
      @(negedge Clk);
      if (n == 1) Req = '0;
      Abort = (n == 4);
      @(posedge Clk); #1;
      if (CntEn) en0++;
      if (Done[0]) dc = cyc;
    end
    @(negedge Clk);
    Abort = 1'b0;
    chk("abort_en_cycles", en0, 4);
    chk("abort_done_cycle", dc, gc + 4);
    repeat (4) @(negedge Clk);
`endif

    // Randomized traffic respecting the request contract
    for (int c = 0; c < 2500; c++) begin
      @(negedge Clk);
      if (c == 1200) Reset_n = 1'b0;
      if (c == 1203) Reset_n = 1'b1;
`ifdef ABORT_EN
      Abort = ($urandom % 8 == 0);
`endif
      for (int i = 0; i < NREQ; i++) begin
        if (Req[i]) begin
          if (Gnt[i]) begin
            if ($urandom % 2 == 0) Req[i] = 1'b0;
          end else if ($urandom % 24 == 0) begin
            Req[i] = 1'b0;
          end
        end else if ($urandom % 4 == 0) begin
          Req[i] = 1'b1;
          ReqSlt[i] = 1'($urandom % 2);
          ReqLen[i*LEN_W +: LEN_W] = ($urandom % 8 == 0) ? LEN_W'($urandom % 40)
                                                          : LEN_W'($urandom % 5);
        end
      end
    end
    @(negedge Clk);
    Req = '0;
`ifdef ABORT_EN
    Abort = 1'b0;
`endif
    repeat (60) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
